clk_period_meter: RTL and testbench

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 120 ++++++++++++
 tb/tb_clk_period_meter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : clk_period_meter
// Function : Measures the period and high time of a slow asynchronous signal
//            in system-clock cycles, and flags a timeout when edges stop.
// Revision : 1.0 - initial release
// ============================================================================
module clk_period_meter #(
   parameter logic [31:0] timeout_limit = 32'd120000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sigIn,
   output logic [31:0] period,
   output logic [31:0] highTime,
   output logic        valid,
   output logic        timeout
);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        s1_q, s2_q, s3_q;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] hi_cap_q, hi_cap_d;
   logic [31:0] period_q, period_d;
   logic [31:0] high_time_q, high_time_d;
   logic        valid_q, valid_d;
   logic        timeout_q, timeout_d;

   logic        w_rise;
   logic        w_fall;
   logic        w_limit;

   // s1/s2 resolve metastability; s3 holds the previous synchronized sample.
   assign w_rise  = s2_q & ~s3_q;
   assign w_fall  = ~s2_q & s3_q;
   assign w_limit = (cnt_q == timeout_limit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         s3_q        <= 1'b0;
         cnt_q       <= 32'd0;
         hi_cap_q    <= 32'd0;
         period_q    <= 32'd0;
         high_time_q <= 32'd0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s1_q        <= sigIn;
         s2_q        <= s1_q;
         s3_q        <= s2_q;
         cnt_q       <= cnt_d;
         hi_cap_q    <= hi_cap_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_cap_d    = hi_cap_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      timeout_d   = timeout_q;

      case (state_q)
         ST_IDLE: begin
            // Reference edge only; timeout stays set until a full measurement.
            if (w_rise) begin
               state_d  = ST_MEASURE;
               cnt_d    = 32'd1;
               hi_cap_d = 32'd0;
            end
         end
         ST_MEASURE: begin
            // A rise takes priority over the limit so period == limit is legal.
            if (w_rise) begin
               period_d    = cnt_q;
               high_time_d = hi_cap_q;
               valid_d     = 1'b1;
               cnt_d       = 32'd1;
               hi_cap_d    = 32'd0;
               timeout_d   = 1'b0;
            end else if (w_limit) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
               cnt_d     = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
               if (w_fall) begin
                  hi_cap_d = cnt_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign period   = period_q;
   assign highTime = high_time_q;
   assign valid    = valid_q;
   assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_clk_period_meter
// Function : Directed self-checking bench for clk_period_meter (three
//            instances with different timeout limits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

   typedef struct {
      int d;
      int p;
      int h;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sig      [3];
   logic [31:0] per      [3];
   logic [31:0] hit      [3];
   logic        vld      [3];
   logic        to       [3];

   int          n_cmp;
   int          n_err;
   longint      cyc;
   longint      last_v   [3];
   logic        prev_vld [3];
   bit          to_ever  [3];
   int          last_p   [3];
   int          last_h   [3];
   exp_t        exp_q    [$];
   longint      t_seen;

   always #5 clk = ~clk;

   clk_period_meter u_dut_a (
      .clk      (clk),
      .reset    (reset),
      .sigIn    (sig[0]),
      .period   (per[0]),
      .highTime (hit[0]),
      .valid    (vld[0]),
      .timeout  (to[0])
   );

   clk_period_meter #(.timeout_limit(32'd1000)) u_dut_b (
      .clk      (clk),
      .reset    (reset),
      .sigIn    (sig[1]),
      .period   (per[1]),
      .highTime (hit[1]),
      .valid    (vld[1]),
      .timeout  (to[1])
   );

   clk_period_meter #(.timeout_limit(32'd100)) u_dut_c (
      .clk      (clk),
      .reset    (reset),
      .sigIn    (sig[2]),
      .period   (per[2]),
      .highTime (hit[2]),
      .valid    (vld[2]),
      .timeout  (to[2])
   );

   task automatic check(input string tag, input longint obs, input longint exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Each valid consumes the oldest expected measurement; valids are
   // spaced by the period they report while measurement is continuous.
   task automatic monitor();
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (to[d] === 1'b1) to_ever[d] = 1'b1;
         if (vld[d] === 1'b1) begin
            check($sformatf("d%0d_valid_single", d), longint'(prev_vld[d]), 0);
            check($sformatf("d%0d_timeout_on_valid", d), longint'(to[d]), 0);
            check($sformatf("d%0d_valid_expected", d), longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check($sformatf("d%0d_valid_dut", d), d, e.d);
               check($sformatf("d%0d_period", d), per[d], e.p);
               check($sformatf("d%0d_highTime", d), hit[d], e.h);
               if (last_v[d] >= 0)
                  check($sformatf("d%0d_valid_spacing", d), cyc - last_v[d], e.p);
            end
            last_v[d] = cyc;
         end
         prev_vld[d] = vld[d];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      monitor();
   endtask

   task automatic push_exp(input int d, input int p, input int h);
      exp_t e;
      e.d = d;
      e.p = p;
      e.h = h;
      exp_q.push_back(e);
   endtask

   // n periods of (p, h) starting with a rising edge; cont means the DUT
   // already holds a reference edge so the first rise completes a period.
   task automatic wave(input int d, input int p, input int h, input int n, input bit cont);
      for (int k = 0; k < n; k++) begin
         if (k > 0 || cont) push_exp(d, last_p[d], last_h[d]);
         for (int c = 0; c < p; c++) begin
            tick();
            sig[d] = (c < h);
         end
         last_p[d] = p;
         last_h[d] = h;
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         sig[d]      = 1'b0;
         last_v[d]   = -1;
         prev_vld[d] = 1'b0;
         to_ever[d]  = 1'b0;
         last_p[d]   = 0;
         last_h[d]   = 0;
      end

      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("d%0d_rst_period", d), per[d], 0);
         check($sformatf("d%0d_rst_highTime", d), hit[d], 0);
         check($sformatf("d%0d_rst_valid", d), longint'(vld[d]), 0);
         check($sformatf("d%0d_rst_timeout", d), longint'(to[d]), 0);
      end
      reset = 1'b0;

      // Minimum pulse: period 4, high 2.
      wave(0, 4, 2, 6, 1'b0);
      check("min_pulse_all_seen", exp_q.size(), 0);

      // Duty change at a constant 100-cycle period.
      wave(0, 100, 30, 3, 1'b1);
      wave(0, 100, 70, 3, 1'b1);
      check("duty_all_seen", exp_q.size(), 0);

      // One full 60000/30000 period, then five 600/300 periods.
      wave(0, 60000, 30000, 1, 1'b1);
      wave(0, 600, 300, 5, 1'b1);
      check("long_all_seen", exp_q.size(), 0);
      check("long_no_timeout", longint'(to[0]), 0);

      // Reset pulse at cnt=50 of a 200-cycle period, during the low phase.
      wave(0, 200, 40, 1, 1'b1);
      push_exp(0, 200, 40);
      for (int c = 0; c < 200; c++) begin
         tick();
         sig[0] = (c < 40);
         if (c == 51) begin
            reset = 1'b1;
         end else if (c == 52) begin
            check("mid_rst_period", per[0], 0);
            check("mid_rst_highTime", hit[0], 0);
            check("mid_rst_valid", longint'(vld[0]), 0);
            check("mid_rst_timeout", longint'(to[0]), 0);
            for (int d = 0; d < 3; d++) last_v[d] = -1;
            reset = 1'b0;
         end
      end
      check("pre_rst_valid_seen", exp_q.size(), 0);
      wave(0, 200, 40, 3, 1'b0);
      check("post_rst_all_seen", exp_q.size(), 0);
      check("post_rst_period", per[0], 200);

      // Stall with timeout_limit = 1000, then resume.
      wave(1, 200, 100, 3, 1'b0);
      t_seen = -1;
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (to[1] === 1'b1 && t_seen < 0) t_seen = cyc;
      end
      check("stall_timeout_latency", t_seen - last_v[1], 1000);
      check("stall_timeout_level", longint'(to[1]), 1);
      check("stall_period_hold", per[1], 200);
      check("stall_highTime_hold", hit[1], 100);
      last_v[1] = -1;
      wave(1, 200, 100, 1, 1'b0);
      check("resume_first_rise_keeps_timeout", longint'(to[1]), 1);
      wave(1, 200, 100, 2, 1'b1);
      check("resume_all_seen", exp_q.size(), 0);
      check("resume_timeout_cleared", longint'(to[1]), 0);

      // Period equal to timeout_limit = 100: the rise must win every time.
      to_ever[2] = 1'b0;
      wave(2, 100, 50, 5, 1'b0);
      check("coincide_never_timeout", longint'(to_ever[2]), 0);
      check("coincide_all_seen", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
